// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: sum = a - b - bin (mod 2), bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic sum,
  output logic bout
);

  assign sum  = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, built around a single full-subtractor cell.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sb, sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d, bo;
  logic             last;

  full_subtractor u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .sum  (d),
    .bout (bo)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start) state_n = ST_SHIFT;
      ST_SHIFT: if (last)  state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // busy/done are flopped from the next state so they never depend combinationally on start
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != ST_IDLE);
      done  <= (state_n == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= borrow_in;
            cnt <= '0;
          end
        end
        ST_SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= {d, sr[WIDTH-1:1]};
          br  <= bo;
          cnt <= cnt + CW'(1);
          // The final bit lands in diff on the same edge that enters DONE
          if (last) begin
            diff       <= {d, sr[WIDTH-1:1]};
            borrow_out <= bo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors plus a model-checked sweep.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         bin_i = 1'b0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W:0] exp_q[$];
  logic       done_prev = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a_i),
    .b          (b_i),
    .borrow_in  (bin_i),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      check("done_single_cycle", {31'd0, done_prev}, 32'd0);
      check("done_expected", {31'd0, exp_q.size() == 0}, 32'd0);
      if (exp_q.size() != 0) begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result", {23'd0, borrow_out, diff}, {23'd0, e});
      end
    end
    done_prev = (done === 1'b1);
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W:0] expv);
    int lat;
    int nbusy;
    bit got;
    exp_q.push_back(expv);
    a_i = a; b_i = b; bin_i = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); bin_i = 1'($urandom);
    nbusy = (busy === 1'b1) ? 1 : 0;
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) got = 1;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, required %0d", lat, W);
    end else begin
      check("latency", lat, W);
      check("busy_cycles", nbusy, W + 1);
    end
    @(posedge clk); #1;
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rbin;
    logic [W:0]   rexp;
    int           ndone;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_diff", {24'd0, diff}, 32'd0);
    check("reset_borrow", {31'd0, borrow_out}, 32'd0);

    run_op(8'h5A, 8'h23, 1'b0, 9'h037);
    run_op(8'h10, 8'h20, 1'b0, 9'h1F0);
    run_op(8'h00, 8'h00, 1'b1, 9'h1FF);
    run_op(8'hFF, 8'hFF, 1'b0, 9'h000);
    run_op(8'h00, 8'h01, 1'b0, 9'h1FF);
    run_op(8'hAB, 8'h12, 1'b1, 9'h098);

    // Starts during SHIFT and DONE must be ignored
    exp_q.push_back(9'h037);
    a_i = 8'h5A; b_i = 8'h23; bin_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int k;
      bit got;
      k = 0; got = 0;
      while (!got && k < 20) begin
        @(posedge clk); #1;
        k++;
        if (k == 2) begin start = 1'b1; a_i = 8'h00; b_i = 8'h01; end
        if (k == 3) start = 1'b0;
        if (done === 1'b1) got = 1;
      end
      check("ignore_latency", k, W);
    end
    start = 1'b1; a_i = 8'h00; b_i = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_done_ignored", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("diff_held", {23'd0, borrow_out, diff}, 32'h037);
    run_op(8'h33, 8'h11, 1'b0, 9'h022);

    // Reset mid-operation discards the partial result
    a_i = 8'h80; b_i = 8'h01; bin_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_diff", {24'd0, diff}, 32'd0);
    check("abort_borrow", {31'd0, borrow_out}, 32'd0);
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    check("abort_no_activity", ndone, 0);
    run_op(8'h80, 8'h01, 1'b0, 9'h07F);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rbin = 1'($urandom);
      rexp = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      run_op(ra, rb, rbin, rexp);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor that computes diff = a - b - borrow_in, one bit per clock, LSB first.
- Built around a single one-bit full-subtractor cell plus a registered borrow, shift registers and a control FSM.
- Sits directly upstream of the full-subtractor cell: it feeds the cell one (a, b, bin) triple per cycle and consumes the cell's sum/bout.
- Serves area-constrained datapaths that trade latency for a single subtractor cell.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- CW, $clog2(WIDTH+1), bit-counter width (derived, not overridden).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepted start cycle.
- b  input  WIDTH  subtrahend; sampled on the accepted start cycle.
- borrow_in  input  1  initial borrow; sampled on the accepted start cycle.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  a - b - borrow_in mod 2^WIDTH; held until the next accepted start.
- borrow_out  output  1  final borrow (1 iff a < b + borrow_in); held with diff.

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, rst.
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - busy=0, done=0, diff=0, borrow_out=0.
  - internal shift registers, borrow register and counter are cleared.
  - Reset overrides start and any in-flight operation; a partial result is discarded and never signalled.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 loads sa<=a, sb<=b, br<=borrow_in, cnt<=0, and goes to SHIFT.
  - diff/borrow_out keep their previous values until DONE updates them.
- SHIFT, each cycle:
  - The cell computes d = sa[0]^sb[0]^br and bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - Update: sa<=sa>>1, sb<=sb>>1, sr<={d, sr[WIDTH-1:1]}, br<=bo, cnt<=cnt+1.
  - After the cycle where cnt==WIDTH-1, go to DONE.
- DONE (exactly one cycle):
  - done=1, diff=sr (fully shifted), borrow_out=br.
  - Next state is IDLE.
  - start in DONE is ignored.
- Latency: start accepted at edge N; done is high during the cycle after edge N+WIDTH. A new start is accepted at earliest one cycle after done.
- start while busy=1 is ignored entirely; the operands are not resampled.
- Arithmetic:
  - Unsigned two's-complement wrap.
  - diff is the low WIDTH bits of a - b - borrow_in.
  - borrow_out is the inverted carry; chaining borrow_out into borrow_in of the next word gives a multi-word subtraction.
- a, b and borrow_in may change freely after the accepted start cycle.
- done and busy are registered outputs (no combinational path from start).

Decomposition:
- Shared package contents:
  - FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) as a typedef.
  - Default WIDTH constant.
- One sub-module is natural: the existing one-bit cell full_subtractor, instantiated once with (a=sa[0], b=sb[0], bin=br) -> (sum=d, bout=bo).
- The FSM, counter and shift registers stay in serial_subtractor.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, borrow_in=0, start one cycle -> done pulse 9 cycles later, diff=0x37, borrow_out=0, busy high 9 cycles.
- a=0x10, b=0x20, borrow_in=0 -> diff=0xF0, borrow_out=1.
- a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1; a=0xFF, b=0xFF, borrow_in=0 -> diff=0x00, borrow_out=0.
- Start with a=0x5A, b=0x23, then assert start with a=0x00, b=0x01 at cycles 3 and 9 (busy/DONE) -> both ignored, result 0x37; a start after done returns to normal operation.
- Reset mid-operation: start a=0x80, b=0x01, assert rst at cycle 4 -> next cycle busy=0, done=0, diff=0, borrow_out=0; no done pulse follows; a fresh start gives the correct 0x7F.
- Random sweep (1000 pairs plus borrow_in) versus the reference model {borrow_out, diff} = {1'b0,a} - {1'b0,b} - borrow_in taken mod 2^(WIDTH+1) -> exact match; done pulse exactly one cycle each time.
